alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_regfile.sv | 32 +++
 rtl/alu_seq_ctrl.sv | 106 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encodings and psr bit indices for the ALU sequencer and its ALU
package alu_pkg;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;
  // psr layout: carry from ADD in bit 0, compare results in bits 4:1
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  function automatic logic op_legal(input logic [7:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_CMP, OP_LSH, OP_ASHU};
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DATA_W register file
// Ports: clk, rst_n (async, clears all entries), we/waddr/wdata sync write,
//        raddr_a/rdata_a and raddr_b/rdata_b async operand reads, dbg_addr/dbg_data async debug read.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] mem [NREGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: four-state IDLE/READ/EXEC/WB sequencer feeding an external combinational ALU
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_op/req_rdest/req_rsrc request;
//        alu_op/alu_a/alu_b to the ALU, alu_result/alu_flags back; psr flags, busy,
//        done (WB pulse), err (illegal-opcode pulse in READ); dbg_addr/dbg_data register peek.
// Option: ALU_SEQ_IMM_EN adds req_imm/req_use_imm so alu_b can take an immediate.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_op,
  input  logic [AW-1:0]     req_rdest,
  input  logic [AW-1:0]     req_rsrc,
`ifdef ALU_SEQ_IMM_EN
  input  logic [DATA_W-1:0] req_imm,
  input  logic              req_use_imm,
`endif
  output logic [7:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [1:0]        state;
  logic [7:0]        op_q;
  logic [AW-1:0]     rdest_q, rsrc_q;
  logic [DATA_W-1:0] res_q, rf_a, rf_b, opb;
  logic [4:0]        flg_q;
  logic              legal, active, we;
  assign legal     = op_legal(op_q);
  assign active    = state != ST_IDLE;
  assign req_ready = !active;
  assign busy      = active;
  assign done      = state == ST_WB;
  assign err       = state == ST_READ && !legal;
  assign we        = done && op_q != OP_CMP;
`ifdef ALU_SEQ_IMM_EN
  logic [DATA_W-1:0] imm_q;
  logic              use_imm_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      imm_q     <= '0;
      use_imm_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      imm_q     <= req_imm;
      use_imm_q <= req_use_imm;
    end
  assign opb = use_imm_q ? imm_q : rf_b;
`else
  assign opb = rf_b;
`endif
  // operands come straight from the RF, which cannot change before WB, so they stay stable through EXEC
  assign alu_op = active ? op_q : '0;
  assign alu_a  = active ? rf_a : '0;
  assign alu_b  = active ? opb : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      rdest_q <= '0;
      rsrc_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      psr     <= '0;
    end else begin
      state <= state == ST_IDLE ? (req_valid ? ST_READ : ST_IDLE) :
               state == ST_READ ? (legal ? ST_EXEC : ST_IDLE) :
               state == ST_EXEC ? ST_WB : ST_IDLE;
      if (req_valid && req_ready) begin
        op_q    <= req_op;
        rdest_q <= req_rdest;
        rsrc_q  <= req_rsrc;
      end
      if (state == ST_EXEC) begin
        res_q <= alu_result;
        flg_q <= alu_flags;
      end
      if (done && op_q == OP_ADD) psr[PSR_C] <= flg_q[PSR_C];
      if (done && op_q == OP_CMP) psr[PSR_N:PSR_L] <= flg_q[PSR_N:PSR_L];
    end
  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (rdest_q),
    .wdata    (res_q),
    .raddr_a  (rdest_q),
    .rdata_a  (rf_a),
    .raddr_b  (rsrc_q),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic        req_ready, busy, done, err;
  logic [7:0]  req_op = '0, alu_op;
  logic [3:0]  req_rdest = '0, req_rsrc = '0, dbg_addr = '0;
  logic [15:0] alu_a, alu_b, alu_result, dbg_data;
  logic [4:0]  alu_flags, psr;
  logic        ovr = 1'b0;
  logic [15:0] ovr_val = '0;
  logic [16:0] sum;
`ifdef ALU_SEQ_IMM_EN
  logic [15:0] req_imm = '0;
  logic        req_use_imm = 1'b0;
`endif
  int checks = 0, failures = 0;
  int lat;
  logic d, e;
  logic [15:0] pre;
  logic [39:0] rdv, exv;
  logic seen;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rdest(req_rdest), .req_rsrc(req_rsrc),
`ifdef ALU_SEQ_IMM_EN
    .req_imm(req_imm), .req_use_imm(req_use_imm),
`endif
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_flags(alu_flags), .psr(psr), .busy(busy), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU stand-in; ADD and CMP return junk in the flag bits the controller must mask off,
  // and ovr lets the bench preload registers through an OR instruction.
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    sum        = '0;
    if (ovr) alu_result = ovr_val;
    else case (alu_op)
      8'h01: alu_result = alu_a & alu_b;
      8'h02: alu_result = alu_a | alu_b;
      8'h03: alu_result = alu_a ^ alu_b;
      8'h05: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[15:0];
        alu_flags  = {4'b1010, sum[16]};
      end
      8'h0B: alu_flags = {$signed(alu_a) < $signed(alu_b), alu_a == alu_b, 1'b0, alu_a < alu_b, 1'b1};
      8'h84: alu_result = alu_a << alu_b[3:0];
      8'h86: alu_result = 16'($signed(alu_a) >>> alu_b[3:0]);
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction at a negedge and follow it to done/err; returns latency in cycles
  // after accept, the READ and EXEC ALU drive, and dbg_data seen in the final busy cycle.
  task automatic run(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                     output int l, output logic dn, output logic er, output logic [15:0] pv,
                     output logic [39:0] r_v, output logic [39:0] e_v);
    int n = 0;
    l = 0; dn = 0; er = 0; pv = '0; r_v = '0; e_v = '0;
    while (!req_ready && n < 8) begin @(negedge clk); n++; end
    req_op = op; req_rdest = rd; req_rsrc = rs; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) r_v = {alu_op, alu_a, alu_b};
      if (c == 2) e_v = {alu_op, alu_a, alu_b};
      if (done || err) begin l = c; dn = done; er = err; pv = dbg_data; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] r, input logic [15:0] v);
    int l;
    logic dn, er;
    logic [15:0] pv;
    logic [39:0] a, b;
    ovr = 1'b1; ovr_val = v;
    run(8'h02, r, r, l, dn, er, pv, a, b);
    ovr = 1'b0;
    chk("load_lat", l, 3);
  endtask

  initial begin
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_psr", psr, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load(1, 16'h0003);
    load(2, 16'h0004);
    dbg_addr = 1;
    run(8'h05, 1, 2, lat, d, e, pre, rdv, exv);
    chk("add_lat", lat, 3);
    chk("add_done", d, 1);
    chk("add_read_drive", rdv, {8'h05, 16'h0003, 16'h0004});
    chk("add_exec_drive", exv, {8'h05, 16'h0003, 16'h0004});
    chk("add_wb_prewrite", pre, 16'h0003);
    chk("add_rf1", dbg_data, 16'h0007);
    chk("add_psr", psr, 5'b00000);
    chk("add_done_pulse", done, 0);
    chk("idle_alu", {alu_op, alu_a, alu_b}, 0);

    load(3, 16'h0005);
    load(4, 16'h0005);
    dbg_addr = 3;
    run(8'h0B, 3, 4, lat, d, e, pre, rdv, exv);
    chk("cmp_done", d, 1);
    chk("cmp_lat", lat, 3);
    chk("cmp_psr", psr, 5'b01000);
    chk("cmp_rf3", dbg_data, 16'h0005);

    load(1, 16'hFFFF);
    load(2, 16'h0001);
    dbg_addr = 1;
    run(8'h05, 1, 2, lat, d, e, pre, rdv, exv);
    chk("addc_rf1", dbg_data, 16'h0000);
    chk("addc_psr", psr, 5'b01001);

    dbg_addr = 2;
    run(8'h01, 2, 2, lat, d, e, pre, rdv, exv);
    chk("same_reg_drive", rdv, {8'h01, 16'h0001, 16'h0001});
    chk("same_reg_rf2", dbg_data, 16'h0001);

    dbg_addr = 1;
    run(8'hFF, 1, 2, lat, d, e, pre, rdv, exv);
    chk("ill_err", e, 1);
    chk("ill_no_done", d, 0);
    chk("ill_lat", lat, 1);
    chk("ill_ready", req_ready, 1);
    chk("ill_err_pulse", err, 0);
    chk("ill_rf1", dbg_data, 16'h0000);
    chk("ill_psr", psr, 5'b01001);

    load(6, 16'h00F0);
    load(7, 16'h0FF0);
    load(8, 16'h0004);
    dbg_addr = 6;
    run(8'h03, 6, 7, lat, d, e, pre, rdv, exv);
    chk("xor_rf6", dbg_data, 16'h0F00);
    run(8'h84, 6, 8, lat, d, e, pre, rdv, exv);
    chk("lsh_rf6", dbg_data, 16'hF000);
    run(8'h86, 6, 8, lat, d, e, pre, rdv, exv);
    chk("ashu_rf6", dbg_data, 16'hFF00);
    run(8'h01, 6, 7, lat, d, e, pre, rdv, exv);
    chk("and_rf6", dbg_data, 16'h0F00);
    chk("logic_psr", psr, 5'b01001);

    req_op = 8'h03; req_rdest = 6; req_rsrc = 7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_psr", psr, 0);
    chk("arst_done", done, 0);
    chk("arst_alu", {alu_op, alu_a, alu_b}, 0);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      if (dbg_data !== 16'h0000) seen = 1'b1;
    end
    chk("arst_rf_zero", seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);

`ifdef ALU_SEQ_IMM_EN
    load(5, 16'h0001);
    req_imm = 16'h0004; req_use_imm = 1'b1;
    dbg_addr = 5;
    run(8'h84, 5, 0, lat, d, e, pre, rdv, exv);
    req_use_imm = 1'b0;
    chk("imm_exec_drive", exv, {8'h84, 16'h0001, 16'h0004});
    chk("imm_lsh_rf5", dbg_data, 16'h0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
